mdu: RTL

Multiply/divide unit for the P6 pipelined CPU, sitting in the E stage beside the ALU and consuming the same forwarded SrcA/SrcB operands. It executes `mult`/`multu`/`div`/`divu` with fixed multi-cycle latency into private HI/LO registers and serves `mfhi`/`mflo`/`mthi`/`mtlo`. It exports `Busy` so the hazard unit can stall later MDU instructions in D.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_latency_ctr.sv | 61 ++++++
 rtl/mdu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Op codes, latency defaults and shared types for the multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  localparam int OP_W = 4;
  localparam int CTR_W = 8;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mdu_latency_ctr.sv
// ============================================================================
// Module : mdu_latency_ctr
// Brief  : Loadable down-counter giving the busy window and the commit pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_latency_ctr
  import mdu_pkg::*;
#(
  parameter int W = CTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done_pulse
);

  mdu_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // done_pulse marks the edge on which the count reaches zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load && (value != '0)) begin
          cnt_d   = value;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(W-1){1'b0}}, 1'b1}) begin
          done_pulse = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: rtl/mdu.sv
// ============================================================================
// Module : mdu
// Brief  : Fixed-latency multiply/divide unit with private HI/LO registers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     SrcA,
  input  logic [31:0]     SrcB,
  input  logic [OP_W-1:0] MDUCtrl,
  input  logic            Start,
  output logic            Busy,
  output logic [31:0]     MDUOut,
  output logic [31:0]     HI,
  output logic [31:0]     LO
);

  logic [31:0]     a_q, b_q;
  logic [OP_W-1:0] op_q;
  logic            calc_q;
  logic [31:0]     pend_hi_q, pend_lo_q;
  logic            pend_we_q;
  logic [31:0]     hi_q, lo_q;

  logic             w_busy, w_done, w_start, w_is_mult;
  logic [CTR_W-1:0] w_lat;
  logic [31:0]      w_res_hi, w_res_lo;
  logic             w_res_we;
  logic [31:0]      w_com_hi, w_com_lo;
  logic             w_com_we;

  assign w_is_mult = (MDUCtrl == OP_MULT) || (MDUCtrl == OP_MULTU);
  assign w_start   = Start && !w_busy && (MDUCtrl >= OP_MULT) && (MDUCtrl <= OP_DIVU);
  assign w_lat     = w_is_mult ? CTR_W'(MULT_CYCLES) : CTR_W'(DIV_CYCLES);

  mdu_latency_ctr #(.W(CTR_W)) u_ctr (
    .clk        (clk),
    .reset      (reset),
    .load       (w_start),
    .value      (w_lat),
    .busy       (w_busy),
    .done_pulse (w_done)
  );

  // Result logic works from the latched operands only.
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_div_zero, w_div_ovf;
  logic        [31:0] w_b_safe;
  logic signed [31:0] w_quo_s, w_rem_s;
  logic        [31:0] w_quo_u, w_rem_u;

  always_comb begin
    w_prod_s   = $signed(a_q) * $signed(b_q);
    w_prod_u   = {32'd0, a_q} * {32'd0, b_q};
    w_div_zero = (b_q == 32'd0);
    w_div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    // Divisor of 1 keeps the dividers defined on the cases handled separately.
    w_b_safe   = (w_div_zero || w_div_ovf) ? 32'd1 : b_q;
    w_quo_s    = $signed(a_q) / $signed(w_b_safe);
    w_rem_s    = $signed(a_q) % $signed(w_b_safe);
    w_quo_u    = a_q / w_b_safe;
    w_rem_u    = a_q % w_b_safe;

    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_we = 1'b1;
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
        w_res_we = 1'b1;
      end
      OP_DIV: begin
        w_res_hi = w_div_ovf ? 32'd0 : w_rem_s;
        w_res_lo = w_div_ovf ? 32'h8000_0000 : w_quo_s;
        w_res_we = !w_div_zero;
      end
      OP_DIVU: begin
        w_res_hi = w_rem_u;
        w_res_lo = w_quo_u;
        w_res_we = !w_div_zero;
      end
      default: ;
    endcase
  end

  // With a one-cycle latency the pending registers have not been filled yet.
  assign w_com_hi = calc_q ? w_res_hi : pend_hi_q;
  assign w_com_lo = calc_q ? w_res_lo : pend_lo_q;
  assign w_com_we = calc_q ? w_res_we : pend_we_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_NOP;
      calc_q    <= 1'b0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      calc_q <= w_start;
      if (w_start) begin
        a_q  <= SrcA;
        b_q  <= SrcB;
        op_q <= MDUCtrl;
      end
      if (calc_q) begin
        pend_hi_q <= w_res_hi;
        pend_lo_q <= w_res_lo;
        pend_we_q <= w_res_we;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (w_done) begin
      if (w_com_we) begin
        hi_q <= w_com_hi;
        lo_q <= w_com_lo;
      end
    end else if (!w_busy) begin
      if (MDUCtrl == OP_MTHI) hi_q <= SrcA;
      if (MDUCtrl == OP_MTLO) lo_q <= SrcA;
    end
  end

  always_comb begin
    MDUOut = 32'd0;
    case (MDUCtrl)
      OP_MFHI: MDUOut = hi_q;
      OP_MFLO: MDUOut = lo_q;
      default: ;
    endcase
  end

  assign Busy = w_busy;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire
